// File: rtl/ddr3_ui_arb.sv
// ddr3_ui_arb: two-port arbiter in front of a DDR3 controller user interface.
// Waits for calibration before issuing anything. Grants one command at a time
// and drives the command and write-data channels. Each returned read beat is
// routed to its requester through a small FIFO of requester IDs.
// Optional build macro: DDR3_ARB_FIXPRI_EN selects fixed priority, where port 0
// wins whenever both ports are eligible. When it is undefined the ports
// alternate (round-robin).
module ddr3_ui_arb #(
    parameter int ADDR_W    = 29,
    parameter int DATA_W    = 256,
    parameter int MASK_W    = 32,
    parameter int TAG_DEPTH = 16
) (
    input  logic              ui_clk,
    input  logic              ui_clk_sync_rst,
    input  logic              init_calib_complete,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic [MASK_W-1:0] r0_wmask,
    output logic              r0_ack,
    output logic              r0_rd_valid,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic [MASK_W-1:0] r1_wmask,
    output logic              r1_ack,
    output logic              r1_rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    output logic [DATA_W-1:0] app_wdf_data,
    output logic [MASK_W-1:0] app_wdf_mask,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,
    input  logic [DATA_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [1:0] {ST_CAL, ST_IDLE, ST_ISSUE} state_t;

    state_t             r_state;
    state_t             w_state_next;

    // Per-port views of the request inputs, indexed by port ID
    logic [1:0]         w_req;
    logic [1:0]         w_we;
    logic [ADDR_W-1:0]  w_addr  [2];
    logic [DATA_W-1:0]  w_wdata [2];
    logic [MASK_W-1:0]  w_wmask [2];
    logic [1:0]         w_elig;

    logic               w_grant;
    logic               w_gnt_sel;
    logic               w_complete;
    logic               w_cmd_fire;
    logic               w_wdf_fire;
    logic               w_cmd_done;
    logic               w_wdf_done;

    logic               r_gnt_port;
    logic               r_cmd_done;
    logic               r_wdf_done;
    logic [1:0]         r_ack;
    logic [ADDR_W-1:0]  r_app_addr;
    logic [2:0]         r_app_cmd;
    logic               r_app_en;
    logic [DATA_W-1:0]  r_app_wdf_data;
    logic [MASK_W-1:0]  r_app_wdf_mask;
    logic               r_app_wdf_wren;
    logic               r_app_wdf_end;

    // Tag FIFO: holds the requester ID of each accepted read, in issue order
    logic               r_tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_tag_cnt;
    logic               w_tag_room;
    logic               w_push;
    logic               w_pop;

    logic [1:0]         r_rd_valid;
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_rd_err;

    assign w_req      = {r1_req, r0_req};
    assign w_we       = {r1_we, r0_we};
    assign w_addr[0]  = r0_addr;
    assign w_addr[1]  = r1_addr;
    assign w_wdata[0] = r0_wdata;
    assign w_wdata[1] = r1_wdata;
    assign w_wmask[0] = r0_wmask;
    assign w_wmask[1] = r1_wmask;

    assign w_tag_room = (r_tag_cnt < CNT_W'(TAG_DEPTH));

    // A read is held back while every tag is in use; writes never are
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_elig
            assign w_elig[gi] = w_req[gi] && (w_we[gi] || w_tag_room);
        end
    endgenerate

`ifdef DDR3_ARB_FIXPRI_EN
    // Port 1 is chosen only when port 0 has nothing eligible
    assign w_gnt_sel = ~w_elig[0];
`else
    logic r_rr_last;

    // On contention, pick the port that was not granted last
    assign w_gnt_sel = w_elig[1] && (!w_elig[0] || !r_rr_last);

    // Remember the last port that completed; starts at port 1 so port 0 wins first
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_rr_last <= 1'b1;
        end else if (w_complete) begin
            r_rr_last <= r_gnt_port;
        end
    end
`endif

    assign w_cmd_fire = r_app_en && app_rdy;
    assign w_wdf_fire = r_app_wdf_wren && app_wdf_rdy;
    assign w_cmd_done = r_cmd_done || w_cmd_fire;
    assign w_wdf_done = r_wdf_done || w_wdf_fire;

    // FSM state register
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_state <= ST_CAL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and grant/complete strobes
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            ST_CAL: begin
                if (init_calib_complete) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!init_calib_complete) begin
                    w_state_next = ST_CAL;
                end else if (|w_elig) begin
                    w_grant      = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A command in flight is always finished, even if calibration drops
                if (w_cmd_done && w_wdf_done) begin
                    w_complete   = 1'b1;
                    w_state_next = init_calib_complete ? ST_IDLE : ST_CAL;
                end
            end
            default: w_state_next = ST_CAL;
        endcase
    end

    // Command and write-data channel registers, done flags and ack pulse
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_gnt_port     <= 1'b0;
            r_cmd_done     <= 1'b0;
            r_wdf_done     <= 1'b0;
            r_ack          <= '0;
            r_app_addr     <= '0;
            r_app_cmd      <= '0;
            r_app_en       <= 1'b0;
            r_app_wdf_data <= '0;
            r_app_wdf_mask <= '0;
            r_app_wdf_wren <= 1'b0;
            r_app_wdf_end  <= 1'b0;
        end else begin
            r_ack <= '0;
            if (w_grant) begin
                r_gnt_port <= w_gnt_sel;
                r_app_addr <= w_addr[w_gnt_sel];
                r_app_en   <= 1'b1;
                r_cmd_done <= 1'b0;
                if (w_we[w_gnt_sel]) begin
                    r_app_cmd      <= CMD_WR;
                    r_app_wdf_data <= w_wdata[w_gnt_sel];
                    r_app_wdf_mask <= w_wmask[w_gnt_sel];
                    r_app_wdf_wren <= 1'b1;
                    r_app_wdf_end  <= 1'b1;
                    r_wdf_done     <= 1'b0;
                end else begin
                    r_app_cmd  <= CMD_RD;
                    r_wdf_done <= 1'b1;
                end
            end else if (r_state == ST_ISSUE) begin
                if (w_cmd_fire) begin
                    r_app_en   <= 1'b0;
                    r_cmd_done <= 1'b1;
                end
                if (w_wdf_fire) begin
                    r_app_wdf_wren <= 1'b0;
                    r_app_wdf_end  <= 1'b0;
                    r_wdf_done     <= 1'b1;
                end
                if (w_complete) begin
                    r_ack[r_gnt_port] <= 1'b1;
                    r_cmd_done        <= 1'b0;
                    r_wdf_done        <= 1'b0;
                end
            end
        end
    end

    // A beat with no tag outstanding is an error, never a pop
    assign w_push = w_cmd_fire && (r_app_cmd == CMD_RD);
    assign w_pop  = app_rd_data_valid && (r_tag_cnt != '0);

    // Tag storage (no reset so it maps onto plain memory)
    always_ff @(posedge ui_clk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr] <= r_gnt_port;
        end
    end

    // Tag FIFO pointers and occupancy
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_tag_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_tag_cnt <= r_tag_cnt + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_tag_cnt <= r_tag_cnt - CNT_W'(1);
            end
        end
    end

    // Read return: register the beat and flag it for the owning port
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_rd_valid <= '0;
            r_rd_data  <= '0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_valid <= '0;
            if (w_pop) begin
                r_rd_data                      <= app_rd_data;
                r_rd_valid[r_tag_mem[r_rd_ptr]] <= 1'b1;
            end
            if (app_rd_data_valid && (r_tag_cnt == '0)) begin
                r_rd_err <= 1'b1;
            end
        end
    end

    assign r0_ack       = r_ack[0];
    assign r1_ack       = r_ack[1];
    assign r0_rd_valid  = r_rd_valid[0];
    assign r1_rd_valid  = r_rd_valid[1];
    assign rd_data      = r_rd_data;
    assign rd_err       = r_rd_err;
    assign app_addr     = r_app_addr;
    assign app_cmd      = r_app_cmd;
    assign app_en       = r_app_en;
    assign app_wdf_data = r_app_wdf_data;
    assign app_wdf_mask = r_app_wdf_mask;
    assign app_wdf_wren = r_app_wdf_wren;
    assign app_wdf_end  = r_app_wdf_end;

endmodule

// File: doc/ddr3_ui_arb.md
# ddr3_ui_arb

Two-port arbiter that shares the 29-bit-address, 256-bit DDR3 controller user interface between two requesters. It holds off all traffic until calibration completes, then grants one command at a time, drives the controller's command and write-data channels, and routes each returned read beat back to the requester that issued it. It sits between user logic and the DDR3 top-level wrapper, entirely in the ui_clk domain.

## Interface
- ADDR_W, 29, user address width; matches the wrapper's app_addr.
- DATA_W, 256, data beat width.
- MASK_W, 32, byte mask width (DATA_W/8).
- TAG_DEPTH, 16, maximum outstanding reads; power of two.

- ui_clk  in  1  controller user clock; the only clock.
- ui_clk_sync_rst  in  1  synchronous, active-high reset.
- init_calib_complete  in  1  calibration done; no command is issued while low.
- rN_req  in  1  request from port N (N = 0, 1); held high until rN_ack.
- rN_we  in  1  1 = write, 0 = read; stable while rN_req is high.
- rN_addr  in  ADDR_W  command address; stable while rN_req is high.
- rN_wdata  in  DATA_W  write beat; stable while rN_req is high.
- rN_wmask  in  MASK_W  write mask, 1 = byte masked; stable while rN_req is high.
- rN_ack  out  1  one-cycle pulse when port N's command is fully accepted.
- rN_rd_valid  out  1  read beat for port N on rd_data.
- rd_data  out  DATA_W  read beat, shared by both ports.
- rd_err  out  1  sticky; set when a read beat arrives with no outstanding tag.
- app_addr  out  ADDR_W; app_cmd  out  3; app_en  out  1.
- app_wdf_data  out  DATA_W; app_wdf_mask  out  MASK_W; app_wdf_wren  out  1; app_wdf_end  out  1.
- app_rdy  in  1; app_wdf_rdy  in  1.
- app_rd_data  in  DATA_W; app_rd_data_valid  in  1.

## Operation
- FSM states: CAL, IDLE, ISSUE.
- CAL: entered on reset; move to IDLE on the first cycle init_calib_complete = 1.
- IDLE arbitration:
  - A port is eligible when its req is high and, for a read, the tag count is below TAG_DEPTH.
  - If both ports are eligible, grant goes to the port not granted last. The round-robin pointer resets to port 1, so port 0 wins first.
  - On grant, register app_addr and app_cmd (3'b000 write, 3'b001 read), assert app_en and go to ISSUE.
  - For a write, also register app_wdf_data and app_wdf_mask, and assert app_wdf_wren and app_wdf_end.
- ISSUE:
  - app_en drops the cycle after app_en && app_rdy is sampled high; set cmd_done.
  - app_wdf_wren and app_wdf_end drop the cycle after app_wdf_wren && app_wdf_rdy is sampled high; set wdf_done. wdf_done is forced to 1 for reads.
  - The data channel may complete before, with, or after the command channel.
  - When both flags are set (including flags set this cycle): pulse the granted port's ack, update the round-robin pointer, clear the flags, return to IDLE.
- Tag FIFO:
  - Push the granted port ID when a read command is accepted (app_en && app_rdy && app_cmd == read).
  - Pop on app_rd_data_valid.
  - Push and pop in the same cycle leave the count unchanged.
- Read return: on pop, register app_rd_data into rd_data and pulse rN_rd_valid for the popped ID.
- Read beat with the FIFO empty: set rd_err, no rN_rd_valid, count stays 0.
- If init_calib_complete falls, the FSM finishes any command in ISSUE, then goes to CAL.

## Timing
- Reset values: every output 0, including app_cmd, app_addr, wdf data and mask. FSM = CAL, tag count = 0, rd_err = 0.
- Reset mid-operation aborts the in-flight command. Outstanding tags are discarded; the controller is reset by the same signal.
- Request to controller: req high in IDLE → app_en high on the next cycle.
- Best-case command acceptance: app_en high; app_rdy = app_wdf_rdy = 1 that cycle → ack the following cycle.
- Throughput: at most one command per 2 cycles (ISSUE → IDLE → ISSUE).
- Read return latency: app_rd_data_valid → rN_rd_valid exactly 1 cycle later. Beats return in issue order.

## Configuration
- DDR3_ARB_FIXPRI_EN defined: fixed priority. Port 0 always wins when both ports are eligible, and the round-robin pointer is not implemented.
- Not defined: round-robin as described in Operation.

## Test plan
- Calibration gate: reset, r0_req = 1 write, init_calib_complete low for 50 cycles → app_en stays 0. Calib goes high → app_en high 2 cycles later, app_cmd = 0, app_addr = r0_addr.
- Fairness: both ports request reads continuously, app_rdy = 1 → grants alternate 0, 1, 0, 1. With DDR3_ARB_FIXPRI_EN → port 0 only.
- Split write channels: app_rdy = 1, app_wdf_rdy = 0 for 5 cycles → app_en drops after 1 cycle, app_wdf_wren stays high 6 cycles, single ack after wdf accepted.
- Read routing: issue reads in order r1, r0, r1, then return 3 beats with values 0xA, 0xB, 0xC → r1_rd_valid/0xA, r0_rd_valid/0xB, r1_rd_valid/0xC, each 1 cycle after app_rd_data_valid.
- Tag full: 16 reads outstanding, a 17th read requested → no app_en until one beat returns. A write request is still granted during the full condition.
- Errors and reset: app_rd_data_valid with no outstanding reads → rd_err = 1, no rN_rd_valid. Reset asserted mid-ISSUE → all outputs 0 next cycle, FSM in CAL.
